seq_mul_radix4: RTL and testbench

Sequential unsigned radix-4 multiplier: consumes 2 multiplier bits per clock and adds a selected multiple {0, A, 2A, 3A} into a shifting accumulator. It sits directly upstream of the 4:1 partial-product select mux in the multiplier datapath. Its PpSel output is the 2-bit select that drives that mux, one digit per iteration. A Start/Busy/Done handshake connects it to the ALU/control unit.

---
 rtl/seq_mul_radix4_if.sv | 18 +
 rtl/seq_mul_radix4.sv | 65 ++++++
 tb/tb_seq_mul_radix4.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_mul_radix4_if.sv
// seq_mul_radix4_if: Start/Busy/Done handshake and operand/result bus of the radix-4 multiplier.
//   Start   - request a multiply (master -> slave)
//   A, B    - multiplicand / multiplier, WIDTH bits (master -> slave)
//   Busy    - multiply in progress (slave -> master)
//   Done    - one-cycle pulse, Product valid (slave -> master)
//   Product - 2*WIDTH-bit unsigned result (slave -> master)
//   PpSel   - current radix-4 digit of B, partial-product mux select (slave -> master)
interface seq_mul_radix4_if #(parameter int WIDTH = 8);
    logic                   Start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   Busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     Product;
    logic [1:0]             PpSel;
    modport master (output Start, A, B, input Busy, Done, Product, PpSel);
    modport slave  (input Start, A, B, output Busy, Done, Product, PpSel);
endinterface

// File: rtl/seq_mul_radix4.sv
// seq_mul_radix4: sequential unsigned radix-4 multiplier, one 2-bit digit of B per clock.
//   Clk   - rising-edge clock
//   Reset - asynchronous active-high reset
//   bus   - seq_mul_radix4_if slave: Start/A/B in, Busy/Done/Product/PpSel out
module seq_mul_radix4 #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    seq_mul_radix4_if.slave  bus
);
    localparam int KW = $clog2(WIDTH / 2);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT              state, nextState;
    logic [WIDTH-1:0]   aReg, bReg;
    logic [KW-1:0]      k;
    logic [2*WIDTH-1:0] acc, accNext, product;
    logic [WIDTH+1:0]   multiple;
    logic [1:0]         ppSel;
    logic               lastIter;

    always_comb begin
        lastIter  = (state == RUN) && (k == K_LAST);
        nextState = (state == RUN) ? (lastIter ? DONE : RUN) : (bus.Start ? RUN : IDLE);
        ppSel     = (state == RUN) ? bReg[{k, 1'b0} +: 2] : 2'b00;
        // 3A is formed as A + 2A in WIDTH+2 bits so the top digit never truncates
        multiple  = (ppSel[0] ? {2'b00, aReg} : '0) + (ppSel[1] ? {1'b0, aReg, 1'b0} : '0);
        accNext   = acc + ((2*WIDTH)'(multiple) << {k, 1'b0});
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            aReg    <= '0;
            bReg    <= '0;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else if (state == RUN) begin
            acc <= accNext;
            k   <= k + KW'(1);
            if (lastIter)
                product <= accNext;
        end else if (bus.Start) begin
            aReg <= bus.A;
            bReg <= bus.B;
            acc  <= '0;
            k    <= '0;
        end
    end

    assign bus.Busy    = (state == RUN);
    assign bus.Done    = (state == DONE);
    assign bus.Product = product;
    assign bus.PpSel   = ppSel;
endmodule

// File: tb/tb_seq_mul_radix4.sv
// tb_seq_mul_radix4: scoreboard bench for seq_mul_radix4 at WIDTH=8.
module tb_seq_mul_radix4;
    localparam int WIDTH = 8;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int passCnt = 0;
    int totalCnt = 0;
    int doneCnt = 0;
    int expDone = 0;
    logic [15:0] expQ[$];
    logic [15:0] lastExp = '0;

    seq_mul_radix4_if #(.WIDTH(WIDTH)) bus ();
    seq_mul_radix4 #(.WIDTH(WIDTH)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        if (obs === exp)
            passCnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: every Done pops the oldest expected product
    always @(negedge Clk) begin
        if (!Reset && bus.Done) begin
            doneCnt++;
            if (expQ.size() == 0)
                checkVal("sbUnderflow", 1, 0);
            else begin
                lastExp = expQ.pop_front();
                checkVal("product", {16'h0, bus.Product}, {16'h0, lastExp});
            end
        end
    end

    // Called at a negedge: drives a request that is accepted at the next posedge
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bus.Start = 1'b1;
        bus.A = a;
        bus.B = b;
        expQ.push_back(16'(a) * 16'(b));
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    // Called at the negedge after acceptance; ends at the Done negedge
    task automatic runPhase(input logic [7:0] b, input bit poke);
        for (int i = 0; i < WIDTH / 2; i++) begin
            checkVal("busy", 32'(bus.Busy), 1);
            checkVal("doneLow", 32'(bus.Done), 0);
            checkVal("ppSel", 32'(bus.PpSel), 32'((b >> (2 * i)) & 8'h3));
            checkVal("productHold", 32'(bus.Product), 32'(lastExp));
            bus.Start = poke && (i == 1);
            bus.A = $urandom_range(0, 255);
            bus.B = $urandom_range(0, 255);
            if (poke && i == 1) begin
                bus.A = 8'd1;
                bus.B = 8'd1;
            end
            @(negedge Clk);
        end
        bus.Start = 1'b0;
        checkVal("doneHigh", 32'(bus.Done), 1);
        checkVal("busyLowInDone", 32'(bus.Busy), 0);
        checkVal("ppSelDone", 32'(bus.PpSel), 0);
        expDone++;
    endtask

    task automatic doOp(input logic [7:0] a, input logic [7:0] b, input bit poke);
        issue(a, b);
        runPhase(b, poke);
        @(negedge Clk);
        checkVal("doneOneCycle", 32'(bus.Done), 0);
        checkVal("idleBusy", 32'(bus.Busy), 0);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        @(negedge Clk);
        checkVal("rstBusy", 32'(bus.Busy), 0);
        checkVal("rstDone", 32'(bus.Done), 0);
        checkVal("rstProduct", 32'(bus.Product), 0);
        checkVal("rstPpSel", 32'(bus.PpSel), 0);
        Reset = 1'b0;
        @(negedge Clk);
        doOp(8'hFF, 8'hFF, 0);
        doOp(8'd13, 8'h0B, 0);
        doOp(8'h00, 8'hA5, 0);
        doOp(8'hA5, 8'h01, 0);
        doOp(8'h12, 8'h34, 1);
        // back-to-back: Start held in the Done cycle
        issue(8'h21, 8'h43);
        runPhase(8'h43, 0);
        issue(8'd2, 8'd3);
        runPhase(8'd3, 0);
        @(negedge Clk);
        // abort during the second RUN cycle
        issue(8'hFF, 8'hFF);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checkVal("abortBusy", 32'(bus.Busy), 0);
        checkVal("abortDone", 32'(bus.Done), 0);
        checkVal("abortProduct", 32'(bus.Product), 0);
        checkVal("abortPpSel", 32'(bus.PpSel), 0);
        void'(expQ.pop_back());
        lastExp = '0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checkVal("postRstDone", 32'(bus.Done), 0);
        doOp(8'h37, 8'h5C, 0);
        repeat (6) @(negedge Clk);
        checkVal("doneCount", 32'(doneCnt), 32'(expDone));
        checkVal("sbEmpty", 32'(expQ.size()), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
